// File: rtl/port_short_monitor.sv
// Port short supervisor: watches signed ADC codes of the port node and flags a short
// when the node sits near 0 V long enough; keeps a short counter and peak magnitude.
module port_short_monitor #(
  parameter int W         = 12,
  parameter int THRESH    = 4,
  parameter int ASSERT_N  = 8,
  parameter int RELEASE_N = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [W-1:0]     sample,
  output logic             short_flag,
  output logic             short_event,
  output logic [CNT_W-1:0] event_count,
  output logic [W-2:0]     peak_mag,
  output logic [1:0]       state
);

  localparam int RUN_MAX = (ASSERT_N > RELEASE_N) ? ASSERT_N : RELEASE_N;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] ASSERT_C  = RUN_W'(ASSERT_N);
  localparam logic [RUN_W-1:0] RELEASE_C = RUN_W'(RELEASE_N);
  localparam logic [W-2:0]     THRESH_C  = (W-1)'(THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    SUSPECT = 2'd2,
    SHORTED = 2'd3
  } state_t;

  state_t            state_q;
  logic [RUN_W-1:0]  run_q;
  logic [RUN_W-1:0]  run_inc;
  logic              short_flag_q;
  logic              short_event_q;
  logic [CNT_W-1:0]  count_q;
  logic [W-2:0]      peak_q;

  logic signed [W-1:0] sample_s;
  logic [W-2:0]        mag;
  logic                in_band;
  logic                take;
  logic                enter_short;

  // |x| with the most negative code clamped so the result fits in W-1 bits
  function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] x);
    logic signed [W-1:0] neg;
    neg = -x;
    if (x[W-1]) begin
      if (x[W-2:0] == '0) return '1;
      return neg[W-2:0];
    end
    return x[W-2:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign sample_s = signed'(sample);
  assign mag      = abs_sat(sample_s);
  assign in_band  = (mag <= THRESH_C);
  assign take     = enable & sample_valid;
  assign run_inc  = run_q + 1'b1;

  assign enter_short = take && in_band &&
                       ((state_q == OPEN && ASSERT_N == 1) ||
                        (state_q == SUSPECT && run_inc == ASSERT_C));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      run_q         <= '0;
      short_flag_q  <= 1'b0;
      short_event_q <= 1'b0;
      count_q       <= '0;
      peak_q        <= '0;
    end else begin
      short_event_q <= 1'b0;
      // Disable wins over any sample-driven transition; no release is counted
      if (!enable) begin
        state_q      <= IDLE;
        run_q        <= '0;
        short_flag_q <= 1'b0;
      end else if (enter_short) begin
        state_q       <= SHORTED;
        run_q         <= '0;
        short_flag_q  <= 1'b1;
        short_event_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: state_q <= OPEN;
          OPEN: begin
            if (take && in_band) begin
              state_q <= SUSPECT;
              run_q   <= RUN_W'(1);
            end
          end
          SUSPECT: begin
            if (take) begin
              if (in_band) begin
                run_q <= run_inc;
              end else begin
                state_q <= OPEN;
                run_q   <= '0;
              end
            end
          end
          SHORTED: begin
            if (take) begin
              if (in_band) begin
                run_q <= '0;
              end else if (run_inc == RELEASE_C) begin
                state_q      <= OPEN;
                run_q        <= '0;
                short_flag_q <= 1'b0;
              end else begin
                run_q <= run_inc;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // clear overrides the increment and peak update of the same edge
      if (clear) begin
        count_q <= '0;
        peak_q  <= '0;
      end else begin
        if (enter_short) count_q <= sat_inc(count_q);
        if (take && mag > peak_q) peak_q <= mag;
      end
    end
  end

  assign short_flag  = short_flag_q;
  assign short_event = short_event_q;
  assign event_count = count_q;
  assign peak_mag    = peak_q;
  assign state       = state_q;

endmodule

// File: tb/tb_port_short_monitor.sv
// Bench for port_short_monitor: a default instance and a fast-short/narrow-counter
// instance share stimulus and are checked against a run-length reference model.
module tb_port_short_monitor;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic [W-1:0] sample = '0;

  logic sf1, se1, sf2, se2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [W-2:0] pk1, pk2;
  logic [1:0] st1, st2;

  always #5 clk = ~clk;

  port_short_monitor dut1 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .sample_valid(sample_valid), .sample(sample),
    .short_flag(sf1), .short_event(se1), .event_count(cnt1),
    .peak_mag(pk1), .state(st1)
  );

  port_short_monitor #(.W(12), .THRESH(4), .ASSERT_N(1), .RELEASE_N(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .sample_valid(sample_valid), .sample(sample),
    .short_flag(sf2), .short_event(se2), .event_count(cnt2),
    .peak_mag(pk2), .state(st2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: state code, in-band streak, out-of-band streak (while shorted)
  int an[2]   = '{8, 1};
  int rn[2]   = '{16, 3};
  int cmax[2] = '{255, 3};
  int m_st[2], m_in[2], m_out[2], m_flag[2], m_ev[2], m_cnt[2], m_pk[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".st1"}, 32'(st1), m_st[0]);
    chk({tag, ".flag1"}, 32'(sf1), m_flag[0]);
    chk({tag, ".ev1"}, 32'(se1), m_ev[0]);
    chk({tag, ".cnt1"}, 32'(cnt1), m_cnt[0]);
    chk({tag, ".pk1"}, 32'(pk1), m_pk[0]);
    chk({tag, ".st2"}, 32'(st2), m_st[1]);
    chk({tag, ".flag2"}, 32'(sf2), m_flag[1]);
    chk({tag, ".ev2"}, 32'(se2), m_ev[1]);
    chk({tag, ".cnt2"}, 32'(cnt2), m_cnt[1]);
    chk({tag, ".pk2"}, 32'(pk2), m_pk[1]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_in[i] = 0; m_out[i] = 0; m_flag[i] = 0;
      m_ev[i] = 0; m_cnt[i] = 0; m_pk[i] = 0;
    end
  endtask

  task automatic model_step(input int sv);
    int mag;
    bit inb, v, go;
    mag = (sv < 0) ? -sv : sv;
    if (mag > 2047) mag = 2047;
    inb = (mag <= 4);
    v = sample_valid;
    for (int i = 0; i < 2; i++) begin
      m_ev[i] = 0;
      go = 0;
      if (!enable) begin
        m_st[i] = 0; m_in[i] = 0; m_out[i] = 0; m_flag[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
      end else if (v) begin
        if (m_flag[i] == 0) begin
          if (inb) begin
            m_in[i] = m_in[i] + 1;
            if (m_in[i] >= an[i]) go = 1;
            else m_st[i] = 2;
          end else begin
            m_in[i] = 0;
            m_st[i] = 1;
          end
        end else begin
          m_out[i] = inb ? 0 : m_out[i] + 1;
          if (m_out[i] >= rn[i]) begin
            m_flag[i] = 0; m_out[i] = 0; m_in[i] = 0; m_st[i] = 1;
          end
        end
      end
      if (go) begin
        m_st[i] = 3; m_flag[i] = 1; m_ev[i] = 1; m_in[i] = 0; m_out[i] = 0;
        if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
      end
      if (enable && v && mag > m_pk[i]) m_pk[i] = mag;
      if (clear) begin
        m_cnt[i] = 0; m_pk[i] = 0;
      end
    end
  endtask

  task automatic step(input logic v, input int s);
    sample_valid = v;
    sample = W'(s);
    model_step(int'($signed(sample)));
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 1) == 1) step(1'b0, int'($urandom_range(0, 4095)));
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    enable = 1'b1;
    step(1'b0, 0);
    chk("idle_to_open", 32'(st1), 1);
    for (int i = 0; i < 5; i++) step(1'b1, 3);
    chk("suspect_run5", 32'(st1), 2);

    // Asynchronous reset in mid-SUSPECT, observed before any clock edge
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_state", 32'(st1), 0);
    #2 rst = 1'b0;
    step(1'b0, 0);
    chk("after_rst_open", 32'(st1), 1);

    for (int i = 0; i < 8; i++) step(1'b1, 3);
    chk("short_flag", 32'(sf1), 1);
    chk("short_event", 32'(se1), 1);
    chk("event_count1", 32'(cnt1), 1);
    chk("peak3", 32'(pk1), 3);
    step(1'b0, 0);
    chk("event_one_cycle", 32'(se1), 0);

    // Release needs an unbroken out-of-band run; invalid cycles are ignored
    for (int i = 0; i < 15; i++) begin step(1'b1, 100); maybe_gap(); end
    step(1'b1, 0);
    for (int i = 0; i < 15; i++) begin step(1'b1, 100); maybe_gap(); end
    chk("hold_before_16th", 32'(sf1), 1);
    step(1'b1, 100);
    chk("release_flag", 32'(sf1), 0);
    chk("release_state", 32'(st1), 1);

    clear = 1'b1;
    step(1'b0, 0);
    clear = 1'b0;
    chk("clear_peak", 32'(pk1), 0);
    chk("clear_count", 32'(cnt1), 0);

    for (int i = 0; i < 7; i++) step(1'b1, -4);
    step(1'b1, 5);
    chk("broken_run_open", 32'(st1), 1);
    for (int i = 0; i < 7; i++) step(1'b1, 0);
    chk("no_assert", 32'(sf1), 0);
    chk("peak5", 32'(pk1), 5);

    step(1'b1, -2048);
    chk("peak_sat", 32'(pk1), 2047);

    for (int i = 0; i < 7; i++) step(1'b1, 1);
    clear = 1'b1;
    step(1'b1, -1);
    clear = 1'b0;
    chk("clear_vs_assert_cnt", 32'(cnt1), 0);
    chk("clear_vs_assert_ev", 32'(se1), 1);
    chk("clear_vs_assert_flag", 32'(sf1), 1);

    for (int i = 0; i < 16; i++) step(1'b1, -300);
    for (int i = 0; i < 8; i++) step(1'b1, 2);
    chk("second_short_cnt", 32'(cnt1), 1);
    enable = 1'b0;
    step(1'b1, 0);
    chk("disable_state", 32'(st1), 0);
    chk("disable_flag", 32'(sf1), 0);
    chk("disable_keep_cnt", 32'(cnt1), 1);

    enable = 1'b1;
    step(1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 50);
    end
    chk("cnt_saturate", 32'(cnt2), 3);

    for (int n = 0; n < 3000; n++) begin
      int s;
      enable = ($urandom_range(0, 99) >= 2);
      clear  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 7) s = int'($urandom_range(0, 12)) - 6;
      else s = int'($urandom_range(0, 4095)) - 2048;
      step(($urandom_range(0, 9) < 7), s);
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/port_short_monitor.md
Name: port_short_monitor

Overview:
- Digital supervisor directly downstream of the analog port/RC node stage.
- Consumes a stream of signed ADC codes of the port node voltage.
- Declares a short when the node stays within a small band around 0 V for ASSERT_N consecutive valid samples, and releases after RELEASE_N consecutive out-of-band samples.
- Keeps a saturating short-event counter and a peak-magnitude register for test readout.

Parameters:
W, 12, sample width in bits (two's complement)
THRESH, 4, in-band limit; a sample is in-band when |sample| <= THRESH
ASSERT_N, 8, consecutive in-band valid samples needed to declare a short (>=1)
RELEASE_N, 16, consecutive out-of-band valid samples needed to release (>=1)
CNT_W, 8, width of the event counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
enable  in  1  monitor enable
clear  in  1  synchronous clear of event_count and peak_mag
sample_valid  in  1  sample qualifier; held samples are ignored
sample  in  W  signed node-voltage code
short_flag  out  1  registered short indication
short_event  out  1  one-cycle pulse on each short assertion
event_count  out  CNT_W  saturating count of short assertions
peak_mag  out  W-1  largest |sample| seen while enabled
state  out  2  FSM state: 0 IDLE, 1 OPEN, 2 SUSPECT, 3 SHORTED

Behaviour:
Reset
- On rst, all outputs and the run counter go to 0 and state goes to IDLE, regardless of clk.
- Release of rst is synchronous to the next edge.

Magnitude
- mag = |sample|, computed in W bits.
- The most negative code saturates to 2^(W-1)-1, so mag fits in W-1 bits.
- in_band = (mag <= THRESH).

Run counter
- Internal, width ceil(log2(max(ASSERT_N, RELEASE_N)+1)).
- Clears on every state change.

FSM (evaluated on each clk edge; no valid sample means hold everything except the enable and clear effects)
- IDLE: run=0, short_flag=0. enable=1 -> OPEN.
- OPEN:
  - valid & in_band: if ASSERT_N=1, go to SHORTED; else go to SUSPECT with run=1.
  - valid & !in_band: stay in OPEN.
- SUSPECT:
  - valid & in_band: run+1. When run+1 == ASSERT_N -> SHORTED.
  - valid & !in_band -> OPEN, run=0.
- SHORTED:
  - valid & !in_band: run+1. When run+1 == RELEASE_N -> OPEN.
  - valid & in_band: run=0, stay in SHORTED.
- enable=0 in any state -> IDLE on the next edge.
  - short_flag clears.
  - No release event is counted.
  - event_count and peak_mag are kept.
- Dropping enable has priority over any sample-driven transition in the same cycle.

Entry to SHORTED
- short_flag=1 and short_event=1 on the edge that samples the qualifying in-band sample.
- short_flag and short_event are visible in the cycle after that sample.
- short_event is high for exactly one cycle.
- event_count increments on that same edge and saturates at 2^CNT_W-1.

Exit from SHORTED
- short_flag=0 on the edge that samples the RELEASE_N-th out-of-band sample.

peak_mag
- On valid while enable=1, peak_mag = max(peak_mag, mag).

clear
- Zeroes event_count and peak_mag on the edge.
- clear has priority over increment and peak update in the same cycle: the result is 0, while short_flag and short_event still assert normally.
- clear does not affect FSM state.

Reset mid-operation
- Reset in SUSPECT or SHORTED immediately returns the block to IDLE with all outputs 0.
- No event is counted.

Test Plan:
- rst pulse mid-SUSPECT (run=5) -> state=0, all outputs 0 immediately, without a clk edge. After release, enable=1 -> state=1 on the next edge.
- Defaults, enable=1, 8 valid samples of +3 -> short_flag=1 and short_event=1 for one cycle in the cycle after the 8th sample; event_count=1; peak_mag=3.
- Defaults, 7 samples of -4, then one sample of 5, then 7 samples of 0 -> no assertion; state returns to 1 after the 5; peak_mag=5.
- From SHORTED: 15 samples of 100, one 0, then 16 samples of 100 -> short_flag drops only after the 16th sample of the final run. Invalid cycles inserted between samples change nothing.
- W=12, sample=-2048 while enabled -> peak_mag=2047. Repeated shorts with CNT_W=2 -> event_count sticks at 3. clear coincident with an assertion -> event_count=0, short_event=1.
- enable dropped while short_flag=1 -> next edge state=0, short_flag=0, event_count unchanged.
